// File: rtl/zrle_dec.sv
// rtl/zrle_dec.sv - zero-run-length decoder: packed MSB-first token stream to one is-one bit per beat.
// Optional sticky stream-error flag enabled by defining ZRLE_DEC_ERR_EN.
module zrle_dec #(
    parameter int DATA_W           = 8,
    parameter int LOG_MAX_ZRLE_LEN = 4,
    parameter int N_BITS_W         = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                last_i,
    input  logic                vld_i,
    output logic                rdy_o,
    input  logic [N_BITS_W-1:0] n_bits_i,
    output logic                is_one_o,
    output logic                last_o,
    output logic                vld_o,
    input  logic                rdy_i,
    output logic                idle_o,
    output logic                err_o
);

    localparam int BW = 2 * DATA_W;
    localparam int AW = $clog2(BW + 1);
    localparam int RW = LOG_MAX_ZRLE_LEN + 1;

    typedef enum logic [1:0] {IDLE, DECODE, ZERO_RUN, DRAIN} state_t;

    state_t                state_q;
    logic [BW-1:0]         buf_q;
    logic [AW-1:0]         avail_q;
    logic [N_BITS_W-1:0]   rem_q;
    logic [RW-1:0]         run_q;
    logic                  got_last_q;

    logic                  msb, one_ok, zero_ok, in_hs, out_hs, fin, early_end;
    logic [AW-1:0]         cons, avail_c, avail_nxt;
    logic [BW-1:0]         buf_nxt;
    logic [LOG_MAX_ZRLE_LEN-1:0] field;

    assign msb     = buf_q[BW-1];
    assign field   = buf_q[BW-2 -: LOG_MAX_ZRLE_LEN];
    assign one_ok  = (state_q == DECODE) && msb && (avail_q >= AW'(1));
    assign zero_ok = (state_q == DECODE) && !msb && (avail_q >= AW'(LOG_MAX_ZRLE_LEN + 1));

    assign vld_o    = one_ok || (state_q == ZERO_RUN);
    assign is_one_o = one_ok;
    assign last_o   = vld_o && (rem_q == N_BITS_W'(1));
    assign idle_o   = (state_q == IDLE);
    assign rdy_o    = (state_q == IDLE || state_q == DRAIN) ? 1'b1
                    : ((avail_q <= AW'(DATA_W)) && !got_last_q);

    assign in_hs  = vld_i && rdy_o;
    assign out_hs = vld_o && rdy_i;
    assign fin    = out_hs && (rem_q == N_BITS_W'(1));
    // No more words will arrive and the buffer cannot hold a whole token.
    assign early_end = (state_q == DECODE) && got_last_q && !one_ok && !zero_ok;

    always_comb begin
        cons = '0;
        if (one_ok && rdy_i)
            cons = AW'(1);
        else if (zero_ok)
            cons = AW'(LOG_MAX_ZRLE_LEN + 1);
        avail_c = avail_q - cons;
        // New word lands right after the bits that survive this cycle's consume.
        buf_nxt = (buf_q << cons)
                | (in_hs ? ({data_i, {DATA_W{1'b0}}} >> avail_c) : {BW{1'b0}});
        avail_nxt = avail_c + (in_hs ? AW'(DATA_W) : AW'(0));
    end

`ifdef ZRLE_DEC_ERR_EN
    logic err_q;
    logic trunc;
    assign trunc = fin && (state_q == ZERO_RUN) && (run_q != RW'(1));
    assign err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (trunc || early_end)
            err_q <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            avail_q    <= '0;
            rem_q      <= '0;
            run_q      <= '0;
            got_last_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        buf_q      <= buf_nxt;
                        avail_q    <= avail_nxt;
                        rem_q      <= n_bits_i;
                        got_last_q <= last_i;
                        state_q    <= DECODE;
                    end
                end
                DECODE, ZERO_RUN: begin
                    if (fin || early_end) begin
                        buf_q      <= '0;
                        avail_q    <= '0;
                        run_q      <= '0;
                        rem_q      <= '0;
                        got_last_q <= 1'b0;
                        state_q    <= (got_last_q || (in_hs && last_i)) ? IDLE : DRAIN;
                    end else begin
                        buf_q      <= buf_nxt;
                        avail_q    <= avail_nxt;
                        got_last_q <= got_last_q || (in_hs && last_i);
                        if (out_hs)
                            rem_q <= rem_q - N_BITS_W'(1);
                        if (zero_ok) begin
                            run_q   <= {1'b0, field} + RW'(1);
                            state_q <= ZERO_RUN;
                        end else if (state_q == ZERO_RUN && out_hs) begin
                            run_q <= run_q - RW'(1);
                            if (run_q == RW'(1))
                                state_q <= DECODE;
                        end
                    end
                end
                DRAIN: begin
                    if (in_hs && last_i)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zrle_dec.sv
// tb/tb_zrle_dec.sv - directed self-checking bench for zrle_dec (DATA_W=8, LOG_MAX_ZRLE_LEN=4).
module tb_zrle_dec;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  data_i;
    logic        last_i;
    logic        vld_i;
    logic        rdy_o;
    logic [15:0] n_bits_i;
    logic        is_one_o;
    logic        last_o;
    logic        vld_o;
    logic        rdy_i;
    logic        idle_o;
    logic        err_o;

    zrle_dec #(.DATA_W(8), .LOG_MAX_ZRLE_LEN(4), .N_BITS_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .last_i(last_i),
        .vld_i(vld_i), .rdy_o(rdy_o), .n_bits_i(n_bits_i), .is_one_o(is_one_o),
        .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  words [4];
    logic        wlast [4];
    int          n_words;
    int          n_got;
    int          stab_viol;
    logic [63:0] bitvec;
    logic [63:0] lastvec;
`ifdef ZRLE_DEC_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    // Streams words[0..n_words-1] and collects output beats; mode 1 = rdy_i on 1 cycle of 3.
    task automatic run_block(input int nb, input int mode, input int max_cyc);
        int   wi = 0;
        int   cyc = 0;
        logic prev_stall = 1'b0;
        logic p_one = 1'b0;
        logic p_last = 1'b0;
        logic done = 1'b0;
        n_got = 0; stab_viol = 0; bitvec = '0; lastvec = '0;
        n_bits_i = 16'(nb);
        while (cyc < max_cyc && !done) begin
            @(negedge clk_i);
            vld_i  = (wi < n_words);
            data_i = (wi < n_words) ? words[wi] : 8'h00;
            last_i = (wi < n_words) ? wlast[wi] : 1'b0;
            rdy_i  = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (prev_stall && (!vld_o || is_one_o !== p_one || last_o !== p_last))
                stab_viol++;
            prev_stall = vld_o && !rdy_i;
            p_one = is_one_o; p_last = last_o;
            if (vld_i && rdy_o) wi++;
            if (vld_o && rdy_i) begin
                bitvec  = {bitvec[62:0], is_one_o};
                lastvec = {lastvec[62:0], last_o};
                n_got++;
                if (last_o && wi >= n_words) done = 1'b1;
            end
            cyc++;
        end
        @(negedge clk_i);
        vld_i = 1'b0; rdy_i = 1'b0; last_i = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; vld_i = 1'b0; rdy_i = 1'b0; data_i = '0; last_i = 1'b0; n_bits_i = '0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if ({rdy_o, idle_o, vld_o, last_o, is_one_o, err_o} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 110000", {rdy_o, idle_o, vld_o, last_o, is_one_o, err_o});
        end
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        words[0] = 8'hC5; wlast[0] = 1'b1; n_words = 1;
        run_block(6, 0, 60);
        n_checks++;
        if (n_got !== 6 || bitvec !== 64'h31 || lastvec !== 64'h1) begin
            n_fail++;
            $display("FAIL basic_bits: got n=%0d bits=%h last=%h expected n=6 bits=31 last=1", n_got, bitvec, lastvec);
        end
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got idle=%b err=%b expected idle=1 err=0", idle_o, err_o);
        end
    endtask

    task automatic test_long_run();
        words[0] = 8'h78; wlast[0] = 1'b1; n_words = 1;
        run_block(16, 0, 60);
        n_checks++;
        if (n_got !== 16 || bitvec !== 64'h0 || lastvec !== 64'h1) begin
            n_fail++;
            $display("FAIL long_run_bits: got n=%0d bits=%h last=%h expected n=16 bits=0 last=1", n_got, bitvec, lastvec);
        end
        n_checks++;
        if (err_o !== 1'b0 || idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL long_run_state: got err=%b idle=%b expected err=0 idle=1", err_o, idle_o);
        end
    endtask

    task automatic test_straddle();
        words[0] = 8'hFE; wlast[0] = 1'b0;
        words[1] = 8'h18; wlast[1] = 1'b1; n_words = 2;
        run_block(10, 0, 60);
        n_checks++;
        if (n_got !== 10 || bitvec !== 64'h3F9 || lastvec !== 64'h1) begin
            n_fail++;
            $display("FAIL straddle_bits: got n=%0d bits=%h last=%h expected n=10 bits=3f9 last=1", n_got, bitvec, lastvec);
        end
        n_checks++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL straddle_idle: got %b expected 1", idle_o);
        end
    endtask

    task automatic test_backpressure();
        words[0] = 8'hC5; wlast[0] = 1'b1; n_words = 1;
        run_block(6, 1, 80);
        n_checks++;
        if (n_got !== 6 || bitvec !== 64'h31 || lastvec !== 64'h1) begin
            n_fail++;
            $display("FAIL backpressure_bits: got n=%0d bits=%h last=%h expected n=6 bits=31 last=1", n_got, bitvec, lastvec);
        end
        n_checks++;
        if (stab_viol !== 0) begin
            n_fail++;
            $display("FAIL backpressure_stable: got %0d unstable stalls expected 0", stab_viol);
        end
    endtask

    task automatic test_early_end();
        words[0] = 8'h80; wlast[0] = 1'b1; n_words = 1;
        run_block(10, 0, 30);
        n_checks++;
        if (n_got !== 2 || bitvec !== 64'h2 || lastvec !== 64'h0) begin
            n_fail++;
            $display("FAIL early_end_bits: got n=%0d bits=%h last=%h expected n=2 bits=2 last=0", n_got, bitvec, lastvec);
        end
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== ERR_EXP) begin
            n_fail++;
            $display("FAIL early_end_state: got idle=%b err=%b expected idle=1 err=%b", idle_o, err_o, ERR_EXP);
        end
    endtask

    task automatic test_truncate();
        do_reset();
        words[0] = 8'h78; wlast[0] = 1'b1; n_words = 1;
        run_block(4, 0, 60);
        n_checks++;
        if (n_got !== 4 || bitvec !== 64'h0 || lastvec !== 64'h1) begin
            n_fail++;
            $display("FAIL truncate_bits: got n=%0d bits=%h last=%h expected n=4 bits=0 last=1", n_got, bitvec, lastvec);
        end
        n_checks++;
        if (idle_o !== 1'b1 || err_o !== ERR_EXP) begin
            n_fail++;
            $display("FAIL truncate_state: got idle=%b err=%b expected idle=1 err=%b", idle_o, err_o, ERR_EXP);
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        n_bits_i = 16'd16;
        @(negedge clk_i);
        vld_i = 1'b1; data_i = 8'h78; last_i = 1'b1; rdy_i = 1'b1;
        @(negedge clk_i);
        vld_i = 1'b0; last_i = 1'b0;
        #1;
        while (!vld_o && waited < 10) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        repeat (3) @(negedge clk_i);
        #1;
        n_checks++;
        if (vld_o !== 1'b1 || is_one_o !== 1'b0 || idle_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_running: got vld=%b one=%b idle=%b expected 1 0 0", vld_o, is_one_o, idle_o);
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (vld_o !== 1'b0 || idle_o !== 1'b1 || rdy_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got vld=%b idle=%b rdy=%b err=%b expected 0 1 1 0", vld_o, idle_o, rdy_o, err_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0; rdy_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_checks++;
        if (vld_o !== 1'b0 || idle_o !== 1'b1 || rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: got vld=%b idle=%b rdy=%b expected 0 1 1", vld_o, idle_o, rdy_o);
        end
        words[0] = 8'hC5; wlast[0] = 1'b1; n_words = 1;
        run_block(6, 0, 60);
        n_checks++;
        if (n_got !== 6 || bitvec !== 64'h31 || lastvec !== 64'h1) begin
            n_fail++;
            $display("FAIL reset_mid_redecode: got n=%0d bits=%h last=%h expected n=6 bits=31 last=1", n_got, bitvec, lastvec);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_run();
        test_straddle();
        test_backpressure();
        test_early_end();
        test_truncate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
